// File: rtl/hist_bin_accumulator_if.sv
// Vote, command, readout and RAM-port bundle for the histogram bin accumulator.
// The master side is the environment (vote source, RAM read data); the slave
// side is the accumulator itself.
interface hist_bin_accumulator_if #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [ADDR_WIDTH-1:0]   in_bin;
   logic [WEIGHT_WIDTH-1:0] in_weight;
   logic                    clr;
   logic                    rd_req;
   logic                    busy;
   logic                    out_valid;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_last;
   logic                    ram_rd_a;
   logic [ADDR_WIDTH-1:0]   ram_addr_a;
   logic [DATA_WIDTH-1:0]   ram_q_a;
   logic                    ram_we_b;
   logic [ADDR_WIDTH-1:0]   ram_addr_b;
   logic [DATA_WIDTH-1:0]   ram_data_b;

   modport master (
      output in_valid, in_bin, in_weight, clr, rd_req, ram_q_a,
      input  in_ready, busy, out_valid, out_data, out_last,
             ram_rd_a, ram_addr_a, ram_we_b, ram_addr_b, ram_data_b
   );

   modport slave (
      input  in_valid, in_bin, in_weight, clr, rd_req, ram_q_a,
      output in_ready, busy, out_valid, out_data, out_last,
             ram_rd_a, ram_addr_a, ram_we_b, ram_addr_b, ram_data_b
   );
endinterface

// File: rtl/hist_bin_accumulator.sv
// HOG orientation-histogram bin accumulator.
// Streams weighted votes into a dual-port RAM with a 3-stage read-modify-write
// pipeline (read on port A, write on port B), forwarding the two most recent
// sums so back-to-back hits on a bin see up-to-date values. Also zeroes the
// histogram on clr and streams every bin out in address order on rd_req.
module hist_bin_accumulator #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   hist_bin_accumulator_if.slave  bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      DRAIN   = 2'd1,
      CLEAR   = 2'd2,
      READOUT = 2'd3
   } state_t;

   // Unsigned add of a zero-extended weight, clamped to all-ones on overflow.
   function automatic logic [DATA_WIDTH-1:0] sat_add(
      input logic [DATA_WIDTH-1:0]   base,
      input logic [WEIGHT_WIDTH-1:0] weight
   );
      logic [DATA_WIDTH:0] wide;
      wide = {1'b0, base} + {{(DATA_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, weight};
      return wide[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide[DATA_WIDTH-1:0];
   endfunction

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
   logic                    term, term_n;
   logic                    pend_clr, pend_clr_n;

   logic                    accept;
   logic                    vld_p1, vld_p2, vld_p3, vld_p4;
   logic                    rvld_p1, rvld_p1_n, rlast_p1, rlast_p1_n;
   logic                    rvld_p2, rlast_p2;

   logic [WEIGHT_WIDTH-1:0] wt_p1, wt_p2;
   logic [ADDR_WIDTH-1:0]   bin_p2, bin_p4;
   logic [DATA_WIDTH-1:0]   sum_p4;
   logic [DATA_WIDTH-1:0]   base_p2, sum_p2;

   logic                    rd_a_n, we_b_n;
   logic [ADDR_WIDTH-1:0]   addr_a_n, addr_b_n;
   logic [DATA_WIDTH-1:0]   data_b_n;
   logic                    busy_n, in_ready_n;
   logic                    out_valid_n, out_last_n;
   logic [DATA_WIDTH-1:0]   out_data_n;

   assign accept = bus.in_valid && bus.in_ready;

   // ---- P2: pick the freshest base for this bin and form the saturated sum
   // Pick P3 first, then the P4 shadow, then RAM data (RAM returns old data on a same-edge write).
   always_comb begin
      base_p2 = bus.ram_q_a;
      if (vld_p3 && (bus.ram_addr_b == bin_p2)) begin
         base_p2 = bus.ram_data_b;
      end else if (vld_p4 && (bin_p4 == bin_p2)) begin
         base_p2 = sum_p4;
      end
      sum_p2 = sat_add(base_p2, wt_p2);
   end

   // Next-state and next-output decode for the FSM and both RAM ports.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      term_n      = term;
      pend_clr_n  = pend_clr;
      rd_a_n      = 1'b0;
      addr_a_n    = bus.ram_addr_a;
      we_b_n      = 1'b0;
      addr_b_n    = bus.ram_addr_b;
      data_b_n    = bus.ram_data_b;
      rvld_p1_n   = 1'b0;
      rlast_p1_n  = 1'b0;

      if (accept) begin
         rd_a_n   = 1'b1;
         addr_a_n = bus.in_bin;
      end
      if (vld_p2) begin
         we_b_n   = 1'b1;
         addr_b_n = bin_p2;
         data_b_n = sum_p2;
      end

      case (state)
         ACCUM: begin
            if (bus.clr) begin
               state_n    = DRAIN;
               pend_clr_n = 1'b1;
            end else if (bus.rd_req) begin
               state_n    = DRAIN;
               pend_clr_n = 1'b0;
            end
         end
         DRAIN: begin
            if (!(vld_p1 || vld_p2 || vld_p3 || vld_p4)) begin
               state_n = pend_clr ? CLEAR : READOUT;
               cnt_n   = '0;
               term_n  = 1'b0;
            end
         end
         CLEAR: begin
            if (!term) begin
               we_b_n   = 1'b1;
               addr_b_n = cnt;
               data_b_n = '0;
               cnt_n    = cnt + 1'b1;
               term_n   = (cnt == LAST_ADDR);
            end else begin
               state_n = ACCUM;
            end
         end
         READOUT: begin
            if (!term) begin
               rd_a_n     = 1'b1;
               addr_a_n   = cnt;
               rvld_p1_n  = 1'b1;
               rlast_p1_n = (cnt == LAST_ADDR);
               cnt_n      = cnt + 1'b1;
               term_n     = (cnt == LAST_ADDR);
            end
            if (bus.out_last) begin
               state_n = ACCUM;
            end
         end
         default: state_n = ACCUM;
      endcase

      busy_n      = (state_n != ACCUM);
      in_ready_n  = (state_n == ACCUM);
      out_valid_n = rvld_p2;
      out_last_n  = rlast_p2;
      out_data_n  = rvld_p2 ? bus.ram_q_a : bus.out_data;
   end

   // FSM state, counters and the command latched for after the drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCUM;
         cnt      <= '0;
         term     <= 1'b0;
         pend_clr <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         term     <= term_n;
         pend_clr <= pend_clr_n;
      end
   end

   // ---- P1/P2/P3/P4 valid flags and all registered block outputs
   // Pipeline valids plus every registered output, cleared immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1         <= 1'b0;
         vld_p2         <= 1'b0;
         vld_p3         <= 1'b0;
         vld_p4         <= 1'b0;
         rvld_p1        <= 1'b0;
         rlast_p1       <= 1'b0;
         rvld_p2        <= 1'b0;
         rlast_p2       <= 1'b0;
         bus.in_ready   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_last   <= 1'b0;
         bus.ram_rd_a   <= 1'b0;
         bus.ram_addr_a <= '0;
         bus.ram_we_b   <= 1'b0;
         bus.ram_addr_b <= '0;
         bus.ram_data_b <= '0;
      end else begin
         vld_p1         <= accept;
         vld_p2         <= vld_p1;
         vld_p3         <= vld_p2;
         vld_p4         <= vld_p3;
         rvld_p1        <= rvld_p1_n;
         rlast_p1       <= rlast_p1_n;
         rvld_p2        <= rvld_p1;
         rlast_p2       <= rlast_p1;
         bus.in_ready   <= in_ready_n;
         bus.busy       <= busy_n;
         bus.out_valid  <= out_valid_n;
         bus.out_data   <= out_data_n;
         bus.out_last   <= out_last_n;
         bus.ram_rd_a   <= rd_a_n;
         bus.ram_addr_a <= addr_a_n;
         bus.ram_we_b   <= we_b_n;
         bus.ram_addr_b <= addr_b_n;
         bus.ram_data_b <= data_b_n;
      end
   end

   // ---- P1 -> P2 weight/bin and P3 -> P4 shadow data (qualified by the valids)
   // Data-only pipeline registers; their meaning is gated by the vld flags.
   always_ff @(posedge clk) begin
      wt_p1  <= bus.in_weight;
      wt_p2  <= wt_p1;
      bin_p2 <= bus.ram_addr_a;
      bin_p4 <= bus.ram_addr_b;
      sum_p4 <= bus.ram_data_b;
   end

endmodule

// File: tb/tb_hist_bin_accumulator.sv
// Testbench for hist_bin_accumulator: behavioural dual-port RAM, a reference
// histogram updated as votes are accepted, and a queue of expected readout
// beats compared as the block streams bins out.
module tb_hist_bin_accumulator;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int WW = 8;
   localparam int NB = 1 << AW;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scramble = 1'b1;

   int checks = 0;
   int errors = 0;
   int beats  = 0;

   int   ref_mem [NB];
   exp_t exp_q [$];

   logic [DW-1:0] mem [NB];

   hist_bin_accumulator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus ();

   hist_bin_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Dual-port RAM: port A reads with one cycle latency, old data on a same-edge write.
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < NB; i++) mem[i] <= DW'(16'hA5A5 ^ (i * 16'h0111));
      end else begin
         if (bus.ram_rd_a) bus.ram_q_a <= mem[bus.ram_addr_a];
         if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
      end
   end

   // Readout scoreboard: every beat must match the next expected bin.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid) begin
         beats++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL readout_unexpected data=%h last=%b", bus.out_data, bus.out_last);
         end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e.data || bus.out_last !== e.last) begin
               errors++;
               $display("FAIL readout_beat%0d data=%h last=%b expected data=%h last=%b",
                        beats - 1, bus.out_data, bus.out_last, e.data, e.last);
            end
         end
         if (bus.out_last === 1'b1) begin
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_at_last busy=%b expected 1", bus.busy);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation timeout");
   end

   function automatic void ref_add(input int b, input int w);
      int s;
      s = ref_mem[b] + w;
      ref_mem[b] = (s > 65535) ? 65535 : s;
   endfunction

   task automatic send_vote(input int b, input int w);
      int n;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_bin    = b[AW-1:0];
      bus.in_weight = w[WW-1:0];
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL vote_accept_timeout in_ready=%b expected 1", bus.in_ready);
      end else begin
         ref_add(b, w);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic push_expected();
      for (int i = 0; i < NB; i++) exp_q.push_back('{data: DW'(ref_mem[i]), last: (i == NB - 1)});
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_timeout busy=%b expected 0", name, bus.busy);
      end
   endtask

   task automatic do_clear(input string name);
      logic [NB-1:0] seen = '0;
      int writes = 0;
      int n = 0;
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_clr_busy busy=%b in_ready=%b expected 1 0", name, bus.busy, bus.in_ready);
      end
      while (bus.busy !== 1'b0 && n < 200) begin
         if (bus.ram_we_b === 1'b1 && bus.ram_data_b === '0) begin
            writes++;
            seen[bus.ram_addr_b] = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (writes != NB || seen !== {NB{1'b1}} || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_clear writes=%0d seen=%h busy=%b in_ready=%b expected %0d ffff 0 1",
                  name, writes, seen, bus.busy, bus.in_ready, NB);
      end
      for (int i = 0; i < NB; i++) ref_mem[i] = 0;
   endtask

   task automatic do_readout(input string name);
      beats = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.rd_req = 1'b1;
      push_expected();
      @(negedge clk);
      bus.rd_req = 1'b0;
      wait_idle(name);
      checks++;
      if (beats != NB || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_beats beats=%0d left=%0d expected %0d 0", name, beats, exp_q.size(), NB);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_bin = '0; bus.in_weight = '0;
      bus.clr = 1'b0; bus.rd_req = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      scramble = 1'b0;
      checks++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.ram_rd_a, bus.ram_we_b} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl rdy,busy,ov,ol,rd,we=%b expected 000000",
                  {bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.ram_rd_a, bus.ram_we_b});
      end
      checks++;
      if (bus.out_data !== '0 || bus.ram_addr_a !== '0 || bus.ram_addr_b !== '0 || bus.ram_data_b !== '0) begin
         errors++;
         $display("FAIL reset_data out=%h aa=%h ab=%h db=%h expected 0",
                  bus.out_data, bus.ram_addr_a, bus.ram_addr_b, bus.ram_data_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release in_ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_clear_readout();
      do_clear("clear0");
      do_readout("zero_readout");
   endtask

   task automatic test_votes();
      do_clear("votes");
      send_vote(3, 5); idle();
      send_vote(7, 2); idle();
      send_vote(3, 1); idle();
      do_readout("votes_readout");
   endtask

   task automatic test_back_to_back();
      do_clear("b2b");
      for (int i = 0; i < 4; i++) send_vote(5, 10);
      idle();
      do_readout("b2b_readout");
   endtask

   task automatic test_hazard();
      do_clear("hazard");
      send_vote(2, 1);
      send_vote(9, 1);
      send_vote(2, 1);
      idle();
      do_readout("hazard_readout");
   endtask

   task automatic test_saturation();
      do_clear("sat");
      for (int i = 0; i < 256; i++) send_vote(0, 255);
      send_vote(0, 240);
      idle();
      send_vote(0, 32);
      send_vote(0, 255);
      send_vote(1, 7);
      idle();
      do_readout("sat_readout");
   endtask

   task automatic test_cmd_collisions();
      int n = 0;
      do_clear("coll");
      send_vote(6, 3); idle();
      beats = 0;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_bin = 4'd4; bus.in_weight = 8'd9;
      bus.rd_req = 1'b1;
      ref_add(4, 9);
      push_expected();
      @(negedge clk);
      bus.rd_req = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL coll_busy busy=%b in_ready=%b expected 1 0", bus.busy, bus.in_ready);
      end
      bus.in_bin = 4'd8;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b0;
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      wait_idle("coll_readout");
      checks++;
      if (beats != NB || exp_q.size() != 0) begin
         errors++;
         $display("FAIL coll_beats beats=%0d left=%0d expected %0d 0", beats, exp_q.size(), NB);
      end
      exp_q.delete();
      do_readout("coll_after_clr");
   endtask

   task automatic test_reset_mid_clear();
      int n = 0;
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      while (bus.ram_we_b !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ram_we_b !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL midclr_active we=%b busy=%b expected 1 1", bus.ram_we_b, bus.busy);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.ram_rd_a, bus.ram_we_b} !== 6'b0 ||
          bus.ram_addr_b !== '0 || bus.ram_data_b !== '0 || bus.ram_addr_a !== '0 || bus.out_data !== '0) begin
         errors++;
         $display("FAIL midclr_reset ctrl=%b ab=%h db=%h aa=%h expected all 0",
                  {bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.ram_rd_a, bus.ram_we_b},
                  bus.ram_addr_b, bus.ram_data_b, bus.ram_addr_a);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midclr_release in_ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy);
      end
      do_clear("recover");
      send_vote(15, 200); idle();
      do_readout("recover_readout");
   endtask

   initial begin
      for (int i = 0; i < NB; i++) ref_mem[i] = 0;
      test_reset();
      test_clear_readout();
      test_votes();
      test_back_to_back();
      test_hazard();
      test_saturation();
      test_cmd_collisions();
      test_reset_mid_clear();
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
